pcie_lane_deskew: RTL and testbench
===================================

Name: pcie_lane_deskew

Overview:
- Receive-side lane-to-lane deskew stage for the 10-bit-per-lane serial link bundle.
- Sits between a link's lane bundle and its consumers: display or link monitors, and endpoint/root-complex receive paths.
- Detects COM (K28.5) on each active lane and delays early lanes so all COMs emerge in the same cycle.
- Flags alignment and reports skew or alignment errors.

Parameters:
- LANES, 16, number of physical lanes in the bundle (1..16).
- MAX_SKEW, 7, largest tolerated lane-to-lane skew in symbol clocks; the delay line is MAX_SKEW+1 deep.

Ports:
- Clk  input  1  symbol clock; all state on rising edge.
- notReset  input  1  asynchronous, active-low reset.
- LinkIn  input  LANES*10  lane bundle; lane i is bits [10i+9:10i].
- LinkWidth  input  5  number of active lanes (1..LANES); lanes at index >= LinkWidth are inactive.
- LinkOut  output  LANES*10  deskewed lane bundle, registered.
- Aligned  output  1  high while in the ALIGNED state.
- SkewErr  output  1  one-cycle pulse on skew timeout or alignment loss.

Behaviour:
- Reset (notReset low, asynchronous): LinkOut=0, Aligned=0, SkewErr=0, all taps=0, skew counter=0, arrival flags cleared, state=HUNT.
- COM match: a lane symbol equal to 10'h0FA (RD-) or 10'h305 (RD+), compared on the raw 10-bit field.
- Per lane, the delay line shifts LinkIn every cycle in all states.
  - LinkOut lane i = delay[tap_i], registered.
  - Latency is 1 cycle at tap 0 and 1+tap_i cycles in general.
- Inactive lanes: tap forced to 0, excluded from all COM checks, still passed through.
- HUNT:
  - Taps hold their previous values; Aligned=0.
  - On the first cycle any active lane on LinkIn shows COM: record arrival a_i=0 for every lane showing COM that cycle, set counter c=0, go to WAIT.
  - If all active lanes show COM in that same cycle, all taps=0 and go directly to ALIGNED (Aligned=1 next cycle).
- WAIT:
  - c increments each cycle; a lane's first COM records a_i=c. Later COMs on an already-recorded lane are ignored.
  - When every active lane is recorded: A = max(a_i), tap_i = A - a_i; go to ALIGNED.
  - If c reaches MAX_SKEW and not all active lanes are recorded after including that cycle: SkewErr pulses for 1 cycle, flags clear, go to HUNT.
- ALIGNED:
  - Aligned=1. Monitor the tapped symbols.
  - If any active lane's tapped symbol is COM while another active lane's is not: SkewErr pulses, Aligned=0 next cycle, go to HUNT. Taps are retained until recomputed.
- LinkWidth change (compared against a registered copy) in any state: go to HUNT, clear flags, Aligned=0, no SkewErr.
- Counters and taps are sized to clog2(MAX_SKEW+1) bits. Taps never exceed MAX_SKEW by construction.

Decomposition:
- Package pcie_deskew_pkg: COM_RDN=10'h0FA, COM_RDP=10'h305, state enum {HUNT, WAIT, ALIGNED}, helper function is_com(10-bit).
- Sub-module pcie_lane_delay, one instance per lane: Clk, notReset, 10-bit In, tap select, registered 10-bit Out.
- Deskew FSM and tap computation live in pcie_lane_deskew.

Test Plan:
- Zero skew: LinkWidth=4; COM 10'h0FA on lanes 0-3 in the same cycle, followed by D-symbols → Aligned=1 next cycle, all taps 0, LinkOut = LinkIn delayed 1 cycle.
- Staggered skew: LinkWidth=4; COM arrives on lanes 0,1,2,3 at c=0,2,3,5 → taps 5,3,2,0. COMs appear on all four LinkOut lanes in the same cycle, 6 cycles after lane 0's input COM. Aligned=1.
- Skew timeout: MAX_SKEW=7; lane 0 COM at c=0, lane 1 COM never arrives → SkewErr pulses exactly once when c=7, state returns to HUNT, Aligned stays 0.
- Alignment loss: after alignment with LinkWidth=2, inject a COM on lane 1 only → SkewErr pulse, Aligned falls next cycle; re-realigns on the next clean COM set.
- Inactive lanes and reset: LinkWidth=1 with random COMs on lanes 1-15 → aligned on lane 0 alone, lanes 1-15 pass through at tap 0. Assert notReset low mid-WAIT → LinkOut=0, Aligned=0, SkewErr=0 immediately, without waiting for a clock edge.
- Width change: LinkWidth changes 4→2 while ALIGNED → Aligned drops next cycle with no SkewErr; aligns again on the next COM set across lanes 0-1.

Source files
------------

// File: rtl/pcie_deskew_pkg.sv
// Shared definitions for the lane deskew block: COM symbol codes, FSM states
// and the COM detector used on both the raw and the tapped lane symbols.
package pcie_deskew_pkg;

    localparam logic [9:0] COM_RDN = 10'h0FA;
    localparam logic [9:0] COM_RDP = 10'h305;

    typedef enum logic [1:0] {
        HUNT,
        WAIT,
        ALIGNED
    } state_t;

    function automatic logic is_com(input logic [9:0] sym);
        return (sym == COM_RDN) || (sym == COM_RDP);
    endfunction

endpackage

// File: rtl/pcie_lane_deskew_if.sv
// Lane bundle between the link, the deskew stage and its consumers.
interface pcie_lane_deskew_if #(
    parameter int LANES = 16
);
    logic [LANES*10-1:0] LinkIn;
    logic [4:0]          LinkWidth;
    logic [LANES*10-1:0] LinkOut;
    logic                Aligned;
    logic                SkewErr;

    modport master (
        output LinkIn, LinkWidth,
        input  LinkOut, Aligned, SkewErr
    );

    modport slave (
        input  LinkIn, LinkWidth,
        output LinkOut, Aligned, SkewErr
    );
endinterface

// File: rtl/pcie_lane_delay.sv
// One lane's delay line: tap 0 selects the live input, tap k the symbol from
// k clocks earlier; the selected symbol is registered onto Out.
module pcie_lane_delay #(
    parameter int MAX_SKEW = 7,
    parameter int TW       = 3
) (
    input  logic          Clk,
    input  logic          notReset,
    input  logic [9:0]    In,
    input  logic [TW-1:0] tap,
    output logic [9:0]    Out
);

    logic [9:0] sr [1:MAX_SKEW];
    logic [9:0] sel;

    always_comb begin
        sel = In;
        for (int k = 1; k <= MAX_SKEW; k++) begin
            if (tap == TW'(k)) sel = sr[k];
        end
    end

    always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            for (int k = 1; k <= MAX_SKEW; k++) sr[k] <= '0;
            Out <= '0;
        end else begin
            sr[1] <= In;
            for (int k = 2; k <= MAX_SKEW; k++) sr[k] <= sr[k-1];
            Out <= sel;
        end
    end

endmodule

// File: rtl/pcie_lane_deskew.sv
// Lane-to-lane deskew: finds COM on each active lane, delays early lanes so
// all COMs leave together, then watches the aligned output for slips.
module pcie_lane_deskew
    import pcie_deskew_pkg::*;
#(
    parameter int LANES    = 16,
    parameter int MAX_SKEW = 7
) (
    input logic               Clk,
    input logic               notReset,
    pcie_lane_deskew_if.slave link
);

    localparam int CW = (MAX_SKEW < 1) ? 1 : $clog2(MAX_SKEW + 1);
    localparam logic [CW-1:0] SKEW_LIM = CW'(MAX_SKEW);

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt, cnt_inc, arr_max;
    logic [LANES-1:0]    seen, seen_nxt, active, com_in, com_out;
    logic [CW-1:0]       arr [LANES];
    logic [CW-1:0]       arr_nxt [LANES];
    logic [CW-1:0]       tap [LANES];
    logic [CW-1:0]       tap_nxt [LANES];
    logic [4:0]          width_q;
    logic                skew_err, skew_err_nxt;
    logic [LANES*10-1:0] link_out;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            active[i]  = 5'(i) < link.LinkWidth;
            com_in[i]  = active[i] && is_com(link.LinkIn[10*i +: 10]);
            com_out[i] = active[i] && is_com(link_out[10*i +: 10]);
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cnt_inc      = cnt + 1'b1;
        seen_nxt     = seen;
        skew_err_nxt = 1'b0;
        arr_max      = '0;
        arr_nxt      = arr;
        tap_nxt      = tap;

        if (link.LinkWidth != width_q) begin
            state_nxt = HUNT;
            seen_nxt  = '0;
        end else begin
            case (state)
                HUNT: begin
                    if (|com_in) begin
                        if (com_in == active) begin
                            for (int i = 0; i < LANES; i++) tap_nxt[i] = '0;
                            state_nxt = ALIGNED;
                        end else begin
                            seen_nxt = com_in;
                            cnt_nxt  = '0;
                            for (int i = 0; i < LANES; i++) arr_nxt[i] = '0;
                            state_nxt = WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_nxt = cnt_inc;
                    for (int i = 0; i < LANES; i++) begin
                        if (com_in[i] && !seen[i]) begin
                            seen_nxt[i] = 1'b1;
                            arr_nxt[i]  = cnt_inc;
                        end
                    end
                    if ((seen_nxt & active) == active) begin
                        // latest arrival defines the common output slot
                        for (int i = 0; i < LANES; i++) begin
                            if (active[i] && (arr_nxt[i] > arr_max)) arr_max = arr_nxt[i];
                        end
                        for (int i = 0; i < LANES; i++) tap_nxt[i] = arr_max - arr_nxt[i];
                        seen_nxt  = '0;
                        state_nxt = ALIGNED;
                    end else if (cnt_inc == SKEW_LIM) begin
                        skew_err_nxt = 1'b1;
                        seen_nxt     = '0;
                        state_nxt    = HUNT;
                    end
                end
                ALIGNED: begin
                    if ((|com_out) && (com_out != active)) begin
                        skew_err_nxt = 1'b1;
                        state_nxt    = HUNT;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end

        for (int i = 0; i < LANES; i++) begin
            if (!active[i]) tap_nxt[i] = '0;
        end
    end

    always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            state    <= HUNT;
            cnt      <= '0;
            seen     <= '0;
            width_q  <= '0;
            skew_err <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                arr[i] <= '0;
                tap[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            seen     <= seen_nxt;
            width_q  <= link.LinkWidth;
            skew_err <= skew_err_nxt;
            for (int i = 0; i < LANES; i++) begin
                arr[i] <= arr_nxt[i];
                tap[i] <= tap_nxt[i];
            end
        end
    end

    // next-cycle taps steer the mux so the COM set that completes alignment
    // already leaves together
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pcie_lane_delay #(
            .MAX_SKEW(MAX_SKEW),
            .TW      (CW)
        ) u_delay (
            .Clk     (Clk),
            .notReset(notReset),
            .In      (link.LinkIn[10*i +: 10]),
            .tap     (tap_nxt[i]),
            .Out     (link_out[10*i +: 10])
        );
    end

    assign link.LinkOut = link_out;
    assign link.Aligned = (state == ALIGNED);
    assign link.SkewErr = skew_err;

endmodule

// File: tb/tb_pcie_lane_deskew.sv
// Directed bench for pcie_lane_deskew; a per-lane tap model predicts LinkOut
// for every cycle and status outputs are checked at each step.
module tb_pcie_lane_deskew;
    import pcie_deskew_pkg::*;

    localparam int LANES = 16;
    localparam int LW    = LANES * 10;

    logic Clk      = 1'b0;
    logic notReset = 1'b0;

    pcie_lane_deskew_if #(.LANES(LANES)) link();

    pcie_lane_deskew #(.LANES(LANES), .MAX_SKEW(7)) dut (
        .Clk     (Clk),
        .notReset(notReset),
        .link    (link)
    );

    always #5 Clk = ~Clk;

    int            n_err = 0;
    int            n_chk = 0;
    logic [LW-1:0] hist [$];
    logic [LW-1:0] exp_q [$];
    int            m_tap [LANES];
    int            dk = 0;
    logic [15:0]   stag [6] = '{16'h1, 16'h0, 16'h2, 16'h4, 16'h0, 16'h8};

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [LW-1:0] dvec();
        logic [LW-1:0] v;
        for (int i = 0; i < LANES; i++) v[10*i +: 10] = {2'b01, 4'(i), 4'(dk)};
        return v;
    endfunction

    function automatic logic [LW-1:0] with_com(input logic [LW-1:0] v, input logic [15:0] mask);
        logic [LW-1:0] r;
        r = v;
        for (int i = 0; i < LANES; i++) if (mask[i]) r[10*i +: 10] = COM_RDN;
        return r;
    endfunction

    function automatic logic [LW-1:0] model_out();
        logic [LW-1:0] r, h;
        for (int i = 0; i < LANES; i++) begin
            h = hist[m_tap[i]];
            r[10*i +: 10] = h[10*i +: 10];
        end
        return r;
    endfunction

    task automatic clear_model();
        hist.delete();
        exp_q.delete();
        repeat (8) hist.push_front('0);
        for (int i = 0; i < LANES; i++) m_tap[i] = 0;
    endtask

    // drive one symbol set, predict its output, then compare after the edge
    task automatic tick(input logic [LW-1:0] v);
        logic [LW-1:0] e;
        link.LinkIn = v;
        hist.push_front(v);
        if (hist.size() > 16) void'(hist.pop_back());
        exp_q.push_back(model_out());
        dk++;
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        chk("link_out", link.LinkOut, e);
    endtask

    task automatic chk_status(input string tag, input logic al, input logic se);
        chk({tag, "_aligned"}, LW'(link.Aligned), LW'(al));
        chk({tag, "_skew_err"}, LW'(link.SkewErr), LW'(se));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [LW-1:0] v;
        link.LinkIn    = '0;
        link.LinkWidth = 5'd4;
        clear_model();
        #12;
        chk("reset_link_out", link.LinkOut, '0);
        chk_status("reset", 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        notReset = 1'b1;

        repeat (3) tick(dvec());
        chk_status("idle", 1'b0, 1'b0);

        // zero skew on four lanes
        v = with_com(dvec(), 16'h000F);
        tick(v);
        chk("zero_skew_com", link.LinkOut[39:0], {4{COM_RDN}});
        chk_status("zero_skew", 1'b1, 1'b0);
        repeat (2) tick(dvec());
        chk_status("zero_skew_hold", 1'b1, 1'b0);

        // width change 4 -> 2 while aligned
        link.LinkWidth = 5'd2;
        tick(dvec());
        chk_status("width_drop", 1'b0, 1'b0);
        tick(dvec());
        chk_status("width_hunt", 1'b0, 1'b0);
        tick(with_com(dvec(), 16'h0003));
        chk_status("width_realign", 1'b1, 1'b0);
        tick(dvec());

        // alignment loss: COM on lane 1 only
        tick(with_com(dvec(), 16'h0002));
        chk_status("loss_inject", 1'b1, 1'b0);
        tick(dvec());
        chk_status("loss_detect", 1'b0, 1'b1);
        tick(dvec());
        chk_status("loss_after", 1'b0, 1'b0);
        tick(with_com(dvec(), 16'h0003));
        chk_status("loss_realign", 1'b1, 1'b0);

        // staggered skew on four lanes: arrivals 0,2,3,5 -> taps 5,3,2,0
        link.LinkWidth = 5'd4;
        tick(dvec());
        chk_status("stag_hunt", 1'b0, 1'b0);
        tick(dvec());
        for (int k = 0; k < 6; k++) begin
            if (k == 5) begin
                m_tap[0] = 5; m_tap[1] = 3; m_tap[2] = 2; m_tap[3] = 0;
            end
            tick(with_com(dvec(), stag[k]));
            if (k < 5) chk_status("stag_wait", 1'b0, 1'b0);
        end
        chk("stag_com", link.LinkOut[39:0], {4{COM_RDN}});
        chk_status("stag_aligned", 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick(with_com(dvec(), (k < 6) ? stag[k] : 16'h0));
            chk_status("stag_repeat", 1'b1, 1'b0);
        end

        // skew timeout: lane 1 COM never arrives
        link.LinkWidth = 5'd2;
        m_tap[2] = 0; m_tap[3] = 0;
        tick(dvec());
        chk_status("to_hunt", 1'b0, 1'b0);
        tick(with_com(dvec(), 16'h0001));
        for (int k = 1; k <= 8; k++) begin
            tick(dvec());
            chk_status("timeout", 1'b0, k == 7);
        end
        m_tap[0] = 0; m_tap[1] = 0;
        tick(with_com(dvec(), 16'h0003));
        chk_status("to_realign", 1'b1, 1'b0);

        // single active lane, noisy inactive lanes
        link.LinkWidth = 5'd1;
        tick(dvec());
        chk_status("w1_hunt", 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            v = dvec();
            for (int i = 1; i < LANES; i++)
                if ($urandom_range(0, 1) == 1) v[10*i +: 10] = COM_RDP;
            if (k == 3) v[9:0] = COM_RDN;
            tick(v);
            chk_status("w1", k == 3, 1'b0);
        end
        tick(dvec());
        chk_status("w1_hold", 1'b1, 1'b0);

        // asynchronous reset in the middle of WAIT
        link.LinkWidth = 5'd2;
        tick(dvec());
        tick(with_com(dvec(), 16'h0001));
        tick(dvec());
        chk_status("mid_wait", 1'b0, 1'b0);
        #2;
        notReset = 1'b0;
        #1;
        chk("async_rst_link_out", link.LinkOut, '0);
        chk_status("async_rst", 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        notReset = 1'b1;
        clear_model();

        tick(dvec());
        tick(with_com(dvec(), 16'h0003));
        chk_status("post_rst_align", 1'b1, 1'b0);
        tick(dvec());

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
